// File: rtl/psram_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : psram_arb_pkg
//  Description : Shared types and constants for the two-master PSRAM arbiter
//  Revision    : 1.0 - initial release
// ============================================================================
package psram_arb_pkg;

   // Watchdog counter width
   localparam int WDT_W = 16;

   // Master identifiers used for the owner / last-granted registers
   localparam logic MASTER_IFETCH = 1'b0;
   localparam logic MASTER_DATA   = 1'b1;

   // Arbiter state encoding
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN   = 2'd1,
      DRAIN = 2'd2,
      GAP   = 2'd3
   } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/bus_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : bus_watchdog
//  Description : Saturating clock counter that flags a missing slave ack once
//                the count reaches a limit; limit 0 disables it
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_watchdog
   import psram_arb_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             i_en,
   input  logic             i_clr,
   input  logic [WDT_W-1:0] i_limit,
   output logic             o_timeout
);

   logic [WDT_W-1:0] r_cnt;
   logic             w_enabled;

   assign w_enabled = (i_limit != '0);

   // Count waiting clocks, hold at the limit, restart whenever cleared
   always_ff @(posedge clk_i) begin
      if (rst_i || i_clr || !w_enabled) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != i_limit)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Timeout only while still waiting, so an ack on the limit clock wins
   assign o_timeout = w_enabled && i_en && (r_cnt == i_limit);

endmodule
`default_nettype wire

// File: rtl/psram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : psram_arbiter
//  Description : Two-master Wishbone arbiter in front of the PSRAM controller
//                with registered grants, an idle gap between owners and a
//                per-strobe ack watchdog
//  Revision    : 1.0 - initial release
// ============================================================================
module psram_arbiter
   import psram_arb_pkg::*;
#(
   parameter logic             FIXED_PRIORITY = 1'b0,
   parameter logic [WDT_W-1:0] TIMEOUT_CLKS   = 16'd256
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        m0_stb_i,
   input  logic        m0_cyc_i,
   input  logic        m0_we_i,
   input  logic [3:0]  m0_sel_i,
   input  logic [21:0] m0_addr_i,
   input  logic [31:0] m0_data_i,
   output logic        m0_ack_o,
   output logic        m0_err_o,
   output logic [31:0] m0_data_o,
   input  logic        m1_stb_i,
   input  logic        m1_cyc_i,
   input  logic        m1_we_i,
   input  logic [3:0]  m1_sel_i,
   input  logic [21:0] m1_addr_i,
   input  logic [31:0] m1_data_i,
   output logic        m1_ack_o,
   output logic        m1_err_o,
   output logic [31:0] m1_data_o,
   output logic        s_stb_o,
   output logic        s_cyc_o,
   output logic        s_we_o,
   output logic [3:0]  s_sel_o,
   output logic [21:0] s_addr_o,
   output logic [31:0] s_data_o,
   input  logic        s_ack_i,
   input  logic [31:0] s_data_i
);

   arb_state_t  r_state;
   arb_state_t  w_state_nxt;
   logic        r_owner;
   logic        r_last;
   logic        w_req0;
   logic        w_req1;
   logic        w_grant;
   logic        w_o_stb;
   logic        w_o_cyc;
   logic        w_o_we;
   logic [3:0]  w_o_sel;
   logic [21:0] w_o_addr;
   logic [31:0] w_o_data;
   logic        w_wdt_en;
   logic        w_timeout;
   logic        w_ack;
   logic        w_err;

   assign w_req0 = m0_cyc_i & m0_stb_i;
   assign w_req1 = m1_cyc_i & m1_stb_i;

   // Owner's bus signals before any watchdog forcing
   assign w_o_stb  = (r_owner == MASTER_DATA) ? m1_stb_i  : m0_stb_i;
   assign w_o_cyc  = (r_owner == MASTER_DATA) ? m1_cyc_i  : m0_cyc_i;
   assign w_o_we   = (r_owner == MASTER_DATA) ? m1_we_i   : m0_we_i;
   assign w_o_sel  = (r_owner == MASTER_DATA) ? m1_sel_i  : m0_sel_i;
   assign w_o_addr = (r_owner == MASTER_DATA) ? m1_addr_i : m0_addr_i;
   assign w_o_data = (r_owner == MASTER_DATA) ? m1_data_i : m0_data_i;

   // Read data goes to both masters; only the owner's ack qualifies it
   assign m0_data_o = s_data_i;
   assign m1_data_o = s_data_i;

   // Watchdog runs while the owner strobes and the slave has not acked
   assign w_wdt_en = (r_state == OWN) && w_o_stb && !s_ack_i;

   bus_watchdog u_wdt (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .i_en      (w_wdt_en),
      .i_clr     (!w_wdt_en),
      .i_limit   (TIMEOUT_CLKS),
      .o_timeout (w_timeout)
   );

   // Arbitration choice: lone requester wins, ties by priority mode
   always_comb begin
      w_grant = MASTER_IFETCH;
      if (w_req0 && w_req1) begin
         w_grant = FIXED_PRIORITY ? MASTER_DATA : ~r_last;
      end else if (w_req1) begin
         w_grant = MASTER_DATA;
      end
   end

   // State, owner and round-robin history registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_owner <= MASTER_IFETCH;
         r_last  <= MASTER_DATA;
      end else begin
         r_state <= w_state_nxt;
         if ((r_state == IDLE) && (w_req0 || w_req1)) begin
            r_owner <= w_grant;
            r_last  <= w_grant;
         end
      end
   end

   // Next-state decode; owner dropping cyc always goes through GAP
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_req0 || w_req1) w_state_nxt = OWN;
         OWN: begin
            if (!w_o_cyc)       w_state_nxt = GAP;
            else if (w_timeout) w_state_nxt = DRAIN;
         end
         DRAIN:   if (!w_o_cyc) w_state_nxt = GAP;
         GAP:     w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Slave-side forwarding and owner ack/err generation
   always_comb begin
      s_stb_o  = 1'b0;
      s_cyc_o  = 1'b0;
      s_we_o   = 1'b0;
      s_sel_o  = '0;
      s_addr_o = '0;
      s_data_o = '0;
      w_ack    = 1'b0;
      w_err    = 1'b0;
      case (r_state)
         OWN: begin
            s_stb_o  = w_o_stb & ~w_timeout;
            s_cyc_o  = w_o_cyc & ~w_timeout;
            s_we_o   = w_o_we;
            s_sel_o  = w_o_sel;
            s_addr_o = w_o_addr;
            s_data_o = w_o_data;
            w_ack    = s_ack_i;
            w_err    = w_timeout;
         end
         DRAIN:   w_err = w_o_stb;
         default: ;
      endcase
      m0_ack_o = w_ack & (r_owner == MASTER_IFETCH);
      m1_ack_o = w_ack & (r_owner == MASTER_DATA);
      m0_err_o = w_err & (r_owner == MASTER_IFETCH);
      m1_err_o = w_err & (r_owner == MASTER_DATA);
   end

endmodule
`default_nettype wire

// File: tb/tb_psram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_psram_arbiter
//  Description : Directed self-checking bench; instance 0 is round-robin with
//                the default watchdog, instance 1 is fixed-priority with an
//                8-clock watchdog
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_psram_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst    [2];
   logic        m0_cyc [2], m0_stb [2], m0_we [2];
   logic [3:0]  m0_sel [2];
   logic [21:0] m0_adr [2];
   logic [31:0] m0_wd  [2];
   logic        m0_ack [2], m0_err [2];
   logic [31:0] m0_rd  [2];
   logic        m1_cyc [2], m1_stb [2], m1_we [2];
   logic [3:0]  m1_sel [2];
   logic [21:0] m1_adr [2];
   logic [31:0] m1_wd  [2];
   logic        m1_ack [2], m1_err [2];
   logic [31:0] m1_rd  [2];
   logic        s_stb  [2], s_cyc [2], s_we [2];
   logic [3:0]  s_sel  [2];
   logic [21:0] s_adr  [2];
   logic [31:0] s_wd   [2];
   logic        s_ack  [2];
   logic [31:0] s_rd   [2];

   int n_cmp = 0;
   int n_bad = 0;

   psram_arbiter #(.FIXED_PRIORITY(1'b0), .TIMEOUT_CLKS(16'd256)) u_rr (
      .clk_i(clk), .rst_i(rst[0]),
      .m0_stb_i(m0_stb[0]), .m0_cyc_i(m0_cyc[0]), .m0_we_i(m0_we[0]),
      .m0_sel_i(m0_sel[0]), .m0_addr_i(m0_adr[0]), .m0_data_i(m0_wd[0]),
      .m0_ack_o(m0_ack[0]), .m0_err_o(m0_err[0]), .m0_data_o(m0_rd[0]),
      .m1_stb_i(m1_stb[0]), .m1_cyc_i(m1_cyc[0]), .m1_we_i(m1_we[0]),
      .m1_sel_i(m1_sel[0]), .m1_addr_i(m1_adr[0]), .m1_data_i(m1_wd[0]),
      .m1_ack_o(m1_ack[0]), .m1_err_o(m1_err[0]), .m1_data_o(m1_rd[0]),
      .s_stb_o(s_stb[0]), .s_cyc_o(s_cyc[0]), .s_we_o(s_we[0]),
      .s_sel_o(s_sel[0]), .s_addr_o(s_adr[0]), .s_data_o(s_wd[0]),
      .s_ack_i(s_ack[0]), .s_data_i(s_rd[0])
   );

   psram_arbiter #(.FIXED_PRIORITY(1'b1), .TIMEOUT_CLKS(16'd8)) u_fp (
      .clk_i(clk), .rst_i(rst[1]),
      .m0_stb_i(m0_stb[1]), .m0_cyc_i(m0_cyc[1]), .m0_we_i(m0_we[1]),
      .m0_sel_i(m0_sel[1]), .m0_addr_i(m0_adr[1]), .m0_data_i(m0_wd[1]),
      .m0_ack_o(m0_ack[1]), .m0_err_o(m0_err[1]), .m0_data_o(m0_rd[1]),
      .m1_stb_i(m1_stb[1]), .m1_cyc_i(m1_cyc[1]), .m1_we_i(m1_we[1]),
      .m1_sel_i(m1_sel[1]), .m1_addr_i(m1_adr[1]), .m1_data_i(m1_wd[1]),
      .m1_ack_o(m1_ack[1]), .m1_err_o(m1_err[1]), .m1_data_o(m1_rd[1]),
      .s_stb_o(s_stb[1]), .s_cyc_o(s_cyc[1]), .s_we_o(s_we[1]),
      .s_sel_o(s_sel[1]), .s_addr_o(s_adr[1]), .s_data_o(s_wd[1]),
      .s_ack_i(s_ack[1]), .s_data_i(s_rd[1])
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic m0_set(input int k, input logic c, input logic s, input logic w,
                         input logic [21:0] a, input logic [31:0] d);
      m0_cyc[k] = c; m0_stb[k] = s; m0_we[k] = w; m0_sel[k] = 4'hF;
      m0_adr[k] = a; m0_wd[k] = d;
   endtask

   task automatic m1_set(input int k, input logic c, input logic s, input logic w,
                         input logic [21:0] a, input logic [31:0] d);
      m1_cyc[k] = c; m1_stb[k] = s; m1_we[k] = w; m1_sel[k] = 4'hF;
      m1_adr[k] = a; m1_wd[k] = d;
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         rst[k] = 1'b1;
         m0_set(k, 0, 0, 0, '0, '0);
         m1_set(k, 0, 0, 0, '0, '0);
         s_ack[k] = 1'b0;
         s_rd[k]  = '0;
      end
      tick; tick;
      rst[0] = 1'b0; rst[1] = 1'b0;
      #1;
      chk("rst_s_cyc",  s_cyc[0],  0);
      chk("rst_s_stb",  s_stb[0],  0);
      chk("rst_m0_ack", m0_ack[0], 0);
      chk("rst_m1_err", m1_err[0], 0);

      // ---------------- single read (instance 0) ----------------
      m0_set(0, 1, 1, 0, 22'h000100, '0);
      #1 chk("rd_idle_stb", s_stb[0], 0);
      tick;
      chk("rd_s_stb",  s_stb[0], 1);
      chk("rd_s_addr", s_adr[0], 32'h100);
      chk("rd_s_sel",  s_sel[0], 32'hF);
      repeat (8) tick;
      chk("rd_no_early_ack", m0_ack[0], 0);
      s_ack[0] = 1'b1; s_rd[0] = 32'hDEADBEEF;
      #1;
      chk("rd_ack",    m0_ack[0], 1);
      chk("rd_data",   m0_rd[0],  32'hDEADBEEF);
      chk("rd_m1_ack", m1_ack[0], 0);
      tick;
      s_ack[0] = 1'b0;
      m0_set(0, 0, 0, 0, '0, '0);
      #1 chk("rd_cyc_drop", s_cyc[0], 0);
      tick;
      chk("rd_gap_cyc", s_cyc[0], 0);
      tick;

      // ---------------- round-robin ties (instance 0) ----------------
      rst[0] = 1'b1; tick; rst[0] = 1'b0;
      m0_set(0, 1, 1, 0, 22'h000AAA, '0);
      m1_set(0, 1, 1, 0, 22'h000BBB, '0);
      tick;
      chk("rr_tie1_addr", s_adr[0], 32'hAAA);
      s_ack[0] = 1'b1;
      #1;
      chk("rr_tie1_m0ack", m0_ack[0], 1);
      chk("rr_nonowner_ack", m1_ack[0], 0);
      tick;
      s_ack[0] = 1'b0;
      m0_set(0, 0, 0, 0, '0, '0);
      tick;
      chk("rr_gap_stb", s_stb[0], 0);
      tick;
      chk("rr_idle_stb", s_stb[0], 0);
      tick;
      chk("rr_second_addr", s_adr[0], 32'hBBB);
      s_ack[0] = 1'b1;
      #1 chk("rr_m1_ack", m1_ack[0], 1);
      tick;
      s_ack[0] = 1'b0;
      m1_set(0, 0, 0, 0, '0, '0);
      tick;
      m0_set(0, 1, 1, 0, 22'h000AAA, '0);
      m1_set(0, 1, 1, 0, 22'h000BBB, '0);
      tick;
      tick;
      chk("rr_tie2_addr", s_adr[0], 32'hAAA);
      m0_set(0, 0, 0, 0, '0, '0);
      m1_set(0, 0, 0, 0, '0, '0);
      tick; tick;

      // ---------------- no preemption burst (instance 0) ----------------
      m0_set(0, 1, 1, 1, 22'h000200, 32'h11111111);
      tick;
      m1_set(0, 1, 1, 0, 22'h3FFFFF, '0);
      s_ack[0] = 1'b1;
      #1;
      chk("np_addr1", s_adr[0], 32'h200);
      chk("np_data1", s_wd[0],  32'h11111111);
      chk("np_m1ack1", m1_ack[0], 0);
      tick;
      m0_set(0, 1, 1, 1, 22'h000201, 32'h22222222);
      #1;
      chk("np_data2", s_wd[0], 32'h22222222);
      chk("np_m1ack2", m1_ack[0], 0);
      tick;
      m0_set(0, 1, 1, 1, 22'h000202, 32'h33333333);
      #1;
      chk("np_data3", s_wd[0],  32'h33333333);
      chk("np_addr3", s_adr[0], 32'h202);
      tick;
      s_ack[0] = 1'b0;
      m0_set(0, 1, 0, 1, 22'h000202, 32'h33333333);
      #1;
      chk("np_hold_addr", s_adr[0], 32'h202);
      chk("np_hold_cyc",  s_cyc[0], 1);
      tick;
      m0_set(0, 0, 0, 0, '0, '0);
      tick;
      chk("np_gap_addr",  s_adr[0],  0);
      chk("np_gap_m1ack", m1_ack[0], 0);
      tick;
      chk("np_idle_addr", s_adr[0], 0);
      tick;
      chk("np_m1_granted", s_adr[0], 32'h3FFFFF);

      // ---------------- reset mid-read (instance 0) ----------------
      rst[0] = 1'b1;
      tick;
      rst[0] = 1'b0;
      s_ack[0] = 1'b1;
      #1;
      chk("rm_s_stb",  s_stb[0],  0);
      chk("rm_s_cyc",  s_cyc[0],  0);
      chk("rm_s_addr", s_adr[0],  0);
      chk("rm_m1_ack", m1_ack[0], 0);
      chk("rm_m1_err", m1_err[0], 0);
      s_ack[0] = 1'b0;
      tick;
      chk("rm_regrant_stb",  s_stb[0], 1);
      chk("rm_regrant_addr", s_adr[0], 32'h3FFFFF);
      m1_set(0, 0, 0, 0, '0, '0);

      // ---------------- fixed priority ties (instance 1) ----------------
      m0_set(1, 1, 1, 0, 22'h000AAA, '0);
      m1_set(1, 1, 1, 0, 22'h000BBB, '0);
      tick;
      chk("fp_tie1_addr", s_adr[1], 32'hBBB);
      s_ack[1] = 1'b1;
      #1;
      chk("fp_tie1_m1ack", m1_ack[1], 1);
      chk("fp_tie1_m0ack", m0_ack[1], 0);
      tick;
      s_ack[1] = 1'b0;
      m1_set(1, 0, 0, 0, '0, '0);
      tick;
      m1_set(1, 1, 1, 0, 22'h000BBB, '0);
      tick;
      tick;
      chk("fp_tie2_addr", s_adr[1], 32'hBBB);
      s_ack[1] = 1'b1;
      tick;
      s_ack[1] = 1'b0;
      m1_set(1, 0, 0, 0, '0, '0);
      tick; tick; tick;
      chk("fp_m0_granted", s_adr[1], 32'hAAA);

      // ---------------- ack exactly at limit (instance 1) ----------------
      repeat (7) tick;
      chk("al_err_pre", m0_err[1], 0);
      tick;
      s_ack[1] = 1'b1;
      #1;
      chk("al_ack", m0_ack[1], 1);
      chk("al_err", m0_err[1], 0);
      chk("al_stb", s_stb[1],  1);
      tick;
      s_ack[1] = 1'b0;
      m0_set(1, 0, 0, 0, '0, '0);
      tick;
      m1_set(1, 1, 1, 0, 22'h000321, '0);
      tick; tick;

      // ---------------- watchdog timeout (instance 1) ----------------
      chk("to_stb_rise", s_stb[1], 1);
      repeat (7) tick;
      chk("to_err_pre", m1_err[1], 0);
      chk("to_stb_pre", s_stb[1],  1);
      tick;
      chk("to_err",      m1_err[1], 1);
      chk("to_stb_fall", s_stb[1],  0);
      chk("to_cyc_fall", s_cyc[1],  0);
      tick;
      chk("to_err_hold",  m1_err[1], 1);
      chk("to_drain_stb", s_stb[1],  0);
      m1_set(1, 1, 0, 0, 22'h000321, '0);
      #1 chk("to_err_release", m1_err[1], 0);
      tick;
      m1_set(1, 0, 0, 0, '0, '0);
      m0_set(1, 1, 1, 0, 22'h000444, '0);
      tick;
      chk("to_gap_cyc", s_cyc[1], 0);
      tick; tick;
      chk("to_next_addr", s_adr[1], 32'h444);
      s_ack[1] = 1'b1;
      #1;
      chk("to_next_ack", m0_ack[1], 1);
      chk("to_next_err", m0_err[1], 0);
      tick;
      s_ack[1] = 1'b0;
      m0_set(1, 0, 0, 0, '0, '0);
      tick;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
